// File: rtl/drink_dispense_arbiter_if.sv
// rtl/drink_dispense_arbiter_if.sv - coin, dispenser handshake and customer output bundle
interface drink_dispense_arbiter_if #(
  parameter int CREDIT_W = 3
);
  logic [1:0]          coin0;
  logic [1:0]          coin1;
  logic                dispense_done;
  logic                dispense_req;
  logic                dispense_id;
  logic                drink0;
  logic                drink1;
  logic [CREDIT_W-1:0] back0;
  logic [CREDIT_W-1:0] back1;
  logic                busy0;
  logic                busy1;

  modport slave (
    input  coin0, coin1, dispense_done,
    output dispense_req, dispense_id, drink0, drink1, back0, back1, busy0, busy1
  );

  modport master (
    output coin0, coin1, dispense_done,
    input  dispense_req, dispense_id, drink0, drink1, back0, back1, busy0, busy1
  );
endinterface

// File: rtl/drink_dispense_arbiter.sv
// rtl/drink_dispense_arbiter.sv - two-port coin front end sharing one dispenser via round-robin
module drink_dispense_arbiter #(
  parameter int PRICE    = 4,
  parameter int CREDIT_W = 3
) (
  input logic                   clk,
  input logic                   reset,
  drink_dispense_arbiter_if.slave bus
);

  typedef enum logic [1:0] {P_IDLE, P_PEND, P_SERV} port_st_e;
  typedef enum logic {A_FREE, A_BUSY} arb_st_e;

  logic [1:0]          coin     [2];
  port_st_e            st_q     [2];
  logic [CREDIT_W-1:0] credit_q [2];
  logic [CREDIT_W-1:0] back_q   [2];
  logic [CREDIT_W-1:0] add_d    [2];
  logic                drink_q  [2];
  arb_st_e             arb_q;
  logic                rr_q;
  logic                req_q;
  logic                id_q;
  logic [1:0]          cand;
  logic                grant_v;
  logic                grant_id;

  assign coin[0] = bus.coin0;
  assign coin[1] = bus.coin1;

  // A cancel in the same cycle removes the port from arbitration.
  always_comb begin
    cand = 2'b00;
    for (int p = 0; p < 2; p++) begin
      add_d[p] = credit_q[p] + CREDIT_W'(coin[p]);
      cand[p]  = (st_q[p] == P_PEND) && (coin[p] != 2'b11);
    end
    grant_v  = (arb_q == A_FREE) && (cand != 2'b00);
    grant_id = (cand == 2'b11) ? rr_q : cand[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        st_q[p]     <= P_IDLE;
        credit_q[p] <= '0;
        back_q[p]   <= '0;
        drink_q[p]  <= 1'b0;
      end
      arb_q <= A_FREE;
      rr_q  <= 1'b0;
      req_q <= 1'b0;
      id_q  <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        drink_q[p] <= 1'b0;
        back_q[p]  <= '0;
        case (st_q[p])
          P_IDLE: begin
            case (coin[p])
              2'b01, 2'b10: begin
                credit_q[p] <= add_d[p];
                if (add_d[p] >= CREDIT_W'(PRICE)) st_q[p] <= P_PEND;
              end
              2'b11: begin
                back_q[p]   <= credit_q[p];
                credit_q[p] <= '0;
              end
              default: ;
            endcase
          end
          P_PEND: begin
            if (coin[p] == 2'b11) begin
              back_q[p]   <= credit_q[p];
              credit_q[p] <= '0;
              st_q[p]     <= P_IDLE;
            end else if (grant_v && (grant_id == 1'(p))) begin
              st_q[p] <= P_SERV;
            end
          end
          P_SERV: begin
            if (bus.dispense_done && (id_q == 1'(p))) begin
              drink_q[p]  <= 1'b1;
              back_q[p]   <= credit_q[p] - CREDIT_W'(PRICE);
              credit_q[p] <= '0;
              st_q[p]     <= P_IDLE;
            end
          end
          default: st_q[p] <= P_IDLE;
        endcase
      end

      case (arb_q)
        A_FREE: begin
          if (grant_v) begin
            req_q <= 1'b1;
            id_q  <= grant_id;
            arb_q <= A_BUSY;
          end
        end
        A_BUSY: begin
          if (bus.dispense_done) begin
            req_q <= 1'b0;
            rr_q  <= ~id_q;
            arb_q <= A_FREE;
          end
        end
        default: arb_q <= A_FREE;
      endcase
    end
  end

  assign bus.dispense_req = req_q;
  assign bus.dispense_id  = id_q;
  assign bus.drink0       = drink_q[0];
  assign bus.drink1       = drink_q[1];
  assign bus.back0        = back_q[0];
  assign bus.back1        = back_q[1];
  assign bus.busy0        = (st_q[0] != P_IDLE);
  assign bus.busy1        = (st_q[1] != P_IDLE);

endmodule

// File: tb/tb_drink_dispense_arbiter.sv
// tb/tb_drink_dispense_arbiter.sv - randomized and directed bench against a credit/queue reference model
module tb_drink_dispense_arbiter;
  localparam int PRICE    = 4;
  localparam int CREDIT_W = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  drink_dispense_arbiter_if #(.CREDIT_W(CREDIT_W)) bus ();

  drink_dispense_arbiter #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: credits, a pending flag per port, and which port (if any) is at the dispenser.
  int cr [2];
  bit pend [2];
  int serving;
  int rr;
  int last_id;
  int e_back [2];
  bit e_drink [2];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      cr[p] = 0; pend[p] = 0; e_back[p] = 0; e_drink[p] = 0;
    end
    serving = -1;
    rr      = 0;
    last_id = 0;
  endtask

  task automatic model_step(input int c0, input int c1, input bit done);
    int c [2];
    int ocr [2];
    bit opend [2];
    bit cand [2];
    int oserv;
    int orr;
    int g;
    c[0] = c0; c[1] = c1;
    oserv = serving;
    orr   = rr;
    for (int p = 0; p < 2; p++) begin
      ocr[p] = cr[p]; opend[p] = pend[p];
      e_back[p] = 0; e_drink[p] = 0;
      cand[p] = (oserv < 0) && opend[p] && (c[p] != 3);
    end
    for (int p = 0; p < 2; p++) begin
      if (oserv == p) begin
        if (done) begin
          e_drink[p] = 1;
          e_back[p]  = ocr[p] - PRICE;
          cr[p]      = 0;
          serving    = -1;
          rr         = 1 - p;
        end
      end else if (opend[p]) begin
        if (c[p] == 3) begin
          e_back[p] = ocr[p];
          cr[p]     = 0;
          pend[p]   = 0;
        end
      end else if (c[p] == 1 || c[p] == 2) begin
        cr[p] = ocr[p] + c[p];
        if (cr[p] >= PRICE) pend[p] = 1;
      end else if (c[p] == 3) begin
        e_back[p] = ocr[p];
        cr[p]     = 0;
      end
    end
    if (cand[0] || cand[1]) begin
      g = (cand[0] && cand[1]) ? orr : (cand[1] ? 1 : 0);
      pend[g] = 0;
      serving = g;
      last_id = g;
    end
  endtask

  task automatic compare_all();
    check("dispense_req", int'(bus.dispense_req), int'(serving >= 0));
    if (serving >= 0) check("dispense_id", int'(bus.dispense_id), serving);
    check("drink0", int'(bus.drink0), int'(e_drink[0]));
    check("drink1", int'(bus.drink1), int'(e_drink[1]));
    check("back0", int'(bus.back0), e_back[0]);
    check("back1", int'(bus.back1), e_back[1]);
    check("busy0", int'(bus.busy0), int'(pend[0] || serving == 0));
    check("busy1", int'(bus.busy1), int'(pend[1] || serving == 1));
    check("drink_exclusive", int'(bus.drink0 && bus.drink1), 0);
  endtask

  task automatic step(input int c0, input int c1, input bit done);
    @(negedge clk);
    bus.coin0         = 2'(c0);
    bus.coin1         = 2'(c1);
    bus.dispense_done = done;
    @(posedge clk);
    model_step(c0, c1, done);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.coin0 = 2'b00;
    bus.coin1 = 2'b00;
    bus.dispense_done = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    // Port 0 pays with two double coins, served, exact change.
    step(2, 0, 0);
    step(2, 0, 0);
    check("busy0_after_price", int'(bus.busy0), 1);
    check("req_not_yet", int'(bus.dispense_req), 0);
    step(0, 0, 0);
    check("req_one_after_busy", int'(bus.dispense_req), 1);
    idle(2);
    step(0, 0, 1);
    check("drink0_pulse", int'(bus.drink0), 1);
    idle(2);

    // Port 1 exact price, then overpay by one.
    step(0, 1, 0); step(0, 1, 0); step(0, 2, 0);
    idle(1); step(0, 0, 1); idle(1);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); step(0, 2, 0);
    idle(2); step(0, 0, 1);
    check("change_back1", int'(bus.back1), 1);
    idle(1);

    // Both ports reach price together: round-robin order with a gap between drinks.
    step(2, 2, 0); step(2, 2, 0);
    idle(2); step(0, 0, 1);
    check("gap_after_done", int'(bus.dispense_req), 0);
    step(0, 0, 0);
    check("second_grant_id", int'(bus.dispense_id), 1);
    step(0, 0, 1);
    idle(1);

    // Cancels: idle refund, then pending refund while the other port is served.
    step(1, 0, 0); step(2, 0, 0); step(3, 0, 0);
    check("cancel_back0", int'(bus.back0), 3);
    step(0, 2, 0); step(0, 2, 0); idle(1);
    step(2, 0, 0); step(2, 0, 0);
    check("pend_while_serv", int'(bus.busy0), 1);
    step(3, 0, 0);
    check("pend_refund_back0", int'(bus.back0), 4);
    step(0, 0, 1); idle(3);

    // Coins ignored in SERV; stray done while free.
    step(2, 0, 0); step(2, 0, 0); idle(1);
    step(3, 0, 0); step(2, 0, 0);
    check("serv_ignores_coins", int'(bus.busy0), 1);
    step(0, 0, 1); idle(1);
    step(0, 0, 1); idle(1);

    // Asynchronous reset mid-dispense with credit 5.
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(2, 0, 0); idle(1);
    @(negedge clk);
    reset = 1'b0;
    bus.coin0 = 2'b00; bus.coin1 = 2'b00; bus.dispense_done = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
    step(2, 0, 0); step(3, 0, 0);
    check("no_stale_credit", int'(bus.back0), 2);

    // Randomized traffic with a randomly answering dispenser.
    for (int i = 0; i < 600; i++) begin
      int c [2];
      for (int p = 0; p < 2; p++) begin
        int r;
        r = int'($urandom_range(0, 9));
        c[p] = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      end
      step(c[0], c[1], ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
